// File: rtl/dcache_controller.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Single outstanding line transaction to backing memory (writeback then fill).
module dcache_controller #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 28 - IdxW;

  if ((NUM_LINES < 2) || (NUM_LINES > 256) || ((NUM_LINES & (NUM_LINES - 1)) != 0))
  begin : gen_bad_num_lines
    $error("NUM_LINES must be a power of two in 2..256");
  end

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, dirty_q;
  logic [TagW-1:0]       tag_q  [NUM_LINES];
  logic [3:0][31:0]      data_q [NUM_LINES];

  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic [1:0]      woff;
  logic            hit, store_hit, fill_done, stall;
  logic            unused_addr;

  assign idx         = cpu_addr_i[4 +: IdxW];
  assign tag         = cpu_addr_i[31 -: TagW];
  assign woff        = cpu_addr_i[3:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit       = (state_q == StIdle) & cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign store_hit = hit & cpu_we_i;
  assign fill_done = (state_q == StFill) & mem_ack_i;

  // Stall is masked by reset so the pipeline is released while reset is held.
  assign cpu_stall_o = stall & rst_i;

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_rdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (hit && !cpu_we_i) begin
          cpu_rdata_o = data_q[idx][woff];
        end
        if (cpu_req_i && !hit) begin
          stall   = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StFill;
        end
      end
      StWriteback: begin
        stall       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 4'b0000};
        mem_wdata_o = data_q[idx];
        if (mem_ack_i) begin
          state_d = StFill;
        end
      end
      StFill: begin
        stall      = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, 4'b0000};
        if (mem_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata_i;
    end else if (store_hit) begin
      data_q[idx][woff] <= cpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller: a word-level shadow memory plus a
// tag/valid/dirty directory predicts hits, memory traffic, penalties and load data.
module tb_dcache_controller;

  localparam int NL = 16;
  localparam int IB = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;

  dcache_controller #(.NUM_LINES(NL)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int txn_cnt = 0;
  int force_lat = 0;

  // Completed memory transactions (request accepted with its ack).
  always @(posedge clk_i) if (mem_req_o && mem_ack_i) txn_cnt++;

  // Shadow = architecturally visible word values; bmem = backing memory contents.
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] bmem   [logic [31:0]];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [31:0] m_tag   [NL];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd_shadow(input logic [31:0] wa);
    return shadow.exists(wa) ? shadow[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_bmem(input logic [31:0] wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] shadow_line(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = rd_shadow(base + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [127:0] bmem_line(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = rd_bmem(base + 32'(4 * w));
    return l;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % NL);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (4 + IB);
  endfunction

  task automatic set_mem_word(input logic [31:0] wa, input logic [31:0] v);
    bmem[wa]   = v;
    shadow[wa] = v;
  endtask

  // Reset discards dirty lines: their stores are lost, memory holds the truth.
  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        logic [31:0] base;
        base = (m_tag[i] << (4 + IB)) | 32'(i << 4);
        for (int w = 0; w < 4; w++) shadow[base + 32'(4 * w)] = rd_bmem(base + 32'(4 * w));
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask

  task automatic mem_phase(input bit exp_we, input logic [31:0] exp_addr,
                           input logic [127:0] exp_wd, input logic [127:0] rd,
                           input int lat, input bit drop, inout int stalls);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (drop && c == 1) cpu_req_i = 1'b0;
      if (c == lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
      end else begin
        mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      if (c == 1 || c == lat) begin
        check("mem_req", mem_req_o, 1'b1);
        check("mem_we", mem_we_o, exp_we);
        check("mem_addr", mem_addr_o, exp_addr);
        check("mem_wdata", mem_wdata_o, exp_wd);
        check("busy_rdata0", cpu_rdata_o, 32'h0);
      end
      stalls += int'(cpu_stall_o);
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit drop);
    logic [31:0] wa, line, victim;
    int          i, txn0, exp_txn, stalls, lw, lf;
    bit          exp_hit;
    wa      = addr & ~32'h3;
    line    = addr & ~32'hF;
    i       = idx_of(addr);
    exp_hit = m_valid[i] && (m_tag[i] == tag_of(addr));
    txn0    = txn_cnt;
    exp_txn = 0;
    stalls  = 0;
    lw      = 0;
    step();
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    #1;
    check("req_stall", cpu_stall_o, !exp_hit);
    if (exp_hit) begin
      check("hit_rdata", cpu_rdata_o, we ? 32'h0 : rd_shadow(wa));
      check("hit_mem_req", mem_req_o, 1'b0);
    end else begin
      check("miss_rdata0", cpu_rdata_o, 32'h0);
      check("miss_mem_req", mem_req_o, 1'b0);
      stalls = 1;
      if (m_valid[i] && m_dirty[i]) begin
        victim = (m_tag[i] << (4 + IB)) | 32'(i << 4);
        lw = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
        mem_phase(1'b1, victim, shadow_line(victim), 128'h0, lw, 1'b0, stalls);
        for (int w = 0; w < 4; w++) bmem[victim + 32'(4 * w)] = rd_shadow(victim + 32'(4 * w));
        exp_txn++;
      end
      lf = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      mem_phase(1'b0, line, 128'h0, bmem_line(line), lf, drop, stalls);
      exp_txn++;
      m_valid[i] = 1'b1;
      m_dirty[i] = 1'b0;
      m_tag[i]   = tag_of(addr);
      if (!drop) begin
        step();
        #1;
        check("refill_stall", cpu_stall_o, 1'b0);
        check("refill_rdata", cpu_rdata_o, we ? 32'h0 : rd_shadow(wa));
        check("penalty", stalls, 1 + lf + lw);
      end
    end
    if (we && (exp_hit || !drop)) begin
      shadow[wa] = wd;
      m_dirty[i] = 1'b1;
    end
    step();
    cpu_req_i = 1'b0;
    check("txn_count", txn_cnt - txn0, exp_txn);
  endtask

  initial begin
    rst_i       = 1'b0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h40;
    cpu_wdata_i = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    step();
    #1;
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 128'h0);
    step();
    cpu_req_i = 1'b0;
    rst_i     = 1'b1;

    // Directed scenarios with fixed ack latency of 3.
    force_lat = 3;
    set_mem_word(32'h44, 32'hDEAD_BEEF);
    access(1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b0, 32'h44, 32'h0, 1'b0);
    access(1'b1, 32'h40, 32'h1234_5678, 1'b0);
    access(1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b0, 32'h140, 32'h0, 1'b0);
    access(1'b1, 32'h80, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 32'h84, 32'h0, 1'b0);
    access(1'b0, 32'h80, 32'h0, 1'b0);
    access(1'b0, 32'h180, 32'h0, 1'b0);

    // Reset asserted in the middle of a fill.
    step();
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h200;
    #1;
    check("rstfill_miss", cpu_stall_o, 1'b1);
    step();
    #1;
    check("rstfill_busy", mem_req_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("rstfill_req0", mem_req_o, 1'b0);
    check("rstfill_stall0", cpu_stall_o, 1'b0);
    step();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 128'h1;
    step();
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    model_reset();
    access(1'b0, 32'h200, 32'h0, 1'b0);

    // Request dropped during fill, then a stray ack while idle.
    access(1'b1, 32'h300, 32'h0BAD_0BAD, 1'b1);
    step();
    mem_ack_i = 1'b1;
    #1;
    check("stray_ack_req", mem_req_o, 1'b0);
    check("stray_ack_stall", cpu_stall_o, 1'b0);
    step();
    access(1'b0, 32'h300, 32'h0, 1'b0);

    // Randomized traffic over a small conflicting address pool.
    force_lat = 0;
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
